// File: rtl/cmd_slave_regfile.sv
// Command-bus responder: decodes single-beat read/write commands into an ID word,
// a sticky EVENT/MASK/IRQ block, scratch, RW control words and RO status words.

module cmd_slave_ctrl_word #(
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        i_sysclk,
  input  logic        i_srst,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] q
);
  always_ff @(posedge i_sysclk) begin
    if (i_srst)  q <= RST_VAL;
    else if (we) q <= wdata;
  end
endmodule

module cmd_slave_regfile #(
  parameter int          CMD_ADDR_BITS  = 24,
  parameter int          NUM_CTRL       = 4,
  parameter int          NUM_STAT       = 4,
  parameter int          ACK_DELAY      = 1,
  parameter logic [31:0] ID_VALUE       = 32'h5157_0001,
  parameter logic [31:0] CTRL_RESET_VAL = 32'h0,
  parameter logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF
) (
  input  logic                       i_sysclk,
  input  logic                       i_srst,
  input  logic                       i_cmd_sel,
  input  logic                       i_cmd_rd_wr_n,
  input  logic [CMD_ADDR_BITS-1:0]   i_cmd_byte_addr,
  input  logic [31:0]                i_cmd_wdata,
  output logic                       o_cmd_ack,
  output logic [31:0]                o_cmd_rdata,
  output logic [32*NUM_CTRL-1:0]     o_ctrl,
  input  logic [32*NUM_STAT-1:0]     i_status,
  input  logic [31:0]                i_event,
  output logic                       o_irq
);
  localparam int WW = CMD_ADDR_BITS - 2;
  localparam int CW = $clog2(ACK_DELAY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ACK_DELAY >= 2 ? ACK_DELAY - 2 : 0);

  generate
    if (ACK_DELAY < 1 || ACK_DELAY > 15) begin : g_bad_delay
      $error("cmd_slave_regfile: ACK_DELAY must be 1..15");
    end
    if (NUM_CTRL < 1 || NUM_CTRL > 64 || NUM_STAT < 1 || NUM_STAT > 64) begin : g_bad_count
      $error("cmd_slave_regfile: NUM_CTRL/NUM_STAT must be 1..64");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic                          lat_rd;
  logic [WW-1:0]                 lat_w;
  logic [31:0]                   lat_wdata;
  logic [31:0]                   ev_q, mask_q, scratch_q;
  logic [NUM_CTRL-1:0][31:0]     ctrl_q;
  logic [NUM_CTRL-1:0]           ctrl_we;

  logic                          c_go, c_rd, wr;
  logic [WW-1:0]                 c_w;
  logic [31:0]                   c_wdata, rd_mux, ev_clr;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, i_cmd_byte_addr[1:0]};

  // The commit happens on the edge entering ACK; with ACK_DELAY=1 that is the
  // sampling edge itself, so the live bus is used instead of the latched copy.
  always_comb begin
    c_go    = 1'b0;
    c_rd    = lat_rd;
    c_w     = lat_w;
    c_wdata = lat_wdata;
    if (state == S_IDLE) begin
      c_go    = i_cmd_sel && (ACK_DELAY == 1);
      c_rd    = i_cmd_rd_wr_n;
      c_w     = i_cmd_byte_addr[CMD_ADDR_BITS-1:2];
      c_wdata = i_cmd_wdata;
    end else if (state == S_WAIT) begin
      c_go = (cnt == '0);
    end
  end

  assign wr     = c_go && !c_rd;
  assign ev_clr = (wr && c_w == WW'(1)) ? c_wdata : 32'h0;

  always_comb begin
    rd_mux = UNMAPPED_RDATA;
    if (c_w == WW'(0)) rd_mux = ID_VALUE;
    if (c_w == WW'(1)) rd_mux = ev_q;
    if (c_w == WW'(2)) rd_mux = mask_q;
    if (c_w == WW'(3)) rd_mux = scratch_q;
    for (int k = 0; k < NUM_CTRL; k++)
      if (c_w == WW'(4 + k)) rd_mux = ctrl_q[k];
    for (int k = 0; k < NUM_STAT; k++)
      if (c_w == WW'(4 + NUM_CTRL + k)) rd_mux = i_status[32*k +: 32];
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CTRL; g++) begin : g_ctrl
      assign ctrl_we[g] = wr && (c_w == WW'(4 + g));
      cmd_slave_ctrl_word #(.RST_VAL(CTRL_RESET_VAL)) u_word (
        .i_sysclk (i_sysclk),
        .i_srst   (i_srst),
        .we       (ctrl_we[g]),
        .wdata    (c_wdata),
        .q        (ctrl_q[g])
      );
    end
  endgenerate

  assign o_ctrl = ctrl_q;

  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lat_rd      <= 1'b0;
      lat_w       <= '0;
      lat_wdata   <= '0;
      o_cmd_ack   <= 1'b0;
      o_cmd_rdata <= '0;
    end else begin
      o_cmd_ack <= 1'b0;
      case (state)
        S_IDLE: if (i_cmd_sel) begin
          lat_rd    <= i_cmd_rd_wr_n;
          lat_w     <= i_cmd_byte_addr[CMD_ADDR_BITS-1:2];
          lat_wdata <= i_cmd_wdata;
          if (ACK_DELAY == 1) begin
            state     <= S_ACK;
            o_cmd_ack <= 1'b1;
          end else begin
            state <= S_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        S_WAIT: if (cnt == '0) begin
          state     <= S_ACK;
          o_cmd_ack <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (c_go && c_rd) o_cmd_rdata <= rd_mux;
    end
  end

  // Set beats clear: a bit pulsed on i_event survives a same-cycle W1C.
  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      ev_q      <= '0;
      mask_q    <= '0;
      scratch_q <= '0;
      o_irq     <= 1'b0;
    end else begin
      ev_q  <= (ev_q & ~ev_clr) | i_event;
      o_irq <= |(ev_q & mask_q);
      if (wr && c_w == WW'(2)) mask_q    <= c_wdata;
      if (wr && c_w == WW'(3)) scratch_q <= c_wdata;
    end
  end
endmodule
